add_sub_logic_pipe: RTL and testbench

//  Parametrised, pipelined successor to the combinational add/sub/logic ALU.

---
 rtl/add_sub_logic_pipe.sv | 126 ++++++++++++
 tb/tb_add_sub_logic_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_logic_pipe.sv
// Two-stage add/sub/compare/logic ALU: S1 registers op/a/b, S2 registers r and flags; latency 2 cycles.
// Valid/ready on both sides: holds two ops when out_ready is low, then drops in_ready; S2 holds steady while stalled.
module add_sub_logic_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] r,
   output logic             carry,
   output logic             ovf,
   output logic             zero,
   output logic             ovf_sticky,
   input  logic             ovf_clr
);
   localparam int MSB = WIDTH - 1;

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_SUB  = 3'd1,
      OP_NOTB = 3'd2,
      OP_LTU  = 3'd3,
      OP_LTS  = 3'd4,
      OP_AND  = 3'd5,
      OP_OR   = 3'd6,
      OP_XOR  = 3'd7
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } s1_t;

   logic             s1_valid;
   s1_t              s1_q;
   logic             s2_valid;
   logic             s1_load;
   logic             s2_load;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] nxt_r;
   logic             nxt_c;
   logic             nxt_ovf;

   assign s2_load   = s1_valid & (~s2_valid | out_ready);
   assign in_ready  = ~s1_valid | s2_load;
   assign s1_load   = in_valid & in_ready;
   assign out_valid = s2_valid;

   // Result logic works from S1 register contents so S2 sees a full cycle of compute.
   always_comb begin
      sum     = '0;
      nxt_r   = '0;
      nxt_c   = 1'b0;
      nxt_ovf = 1'b0;
      case (s1_q.op)
         OP_ADD: begin
            sum     = {1'b0, s1_q.a} + {1'b0, s1_q.b};
            nxt_r   = sum[WIDTH-1:0];
            nxt_c   = sum[WIDTH];
            nxt_ovf = (s1_q.a[MSB] == s1_q.b[MSB]) && (nxt_r[MSB] != s1_q.a[MSB]);
         end
         OP_SUB: begin
            sum     = {1'b0, s1_q.a} + {1'b0, ~s1_q.b} + (WIDTH+1)'(1);
            nxt_r   = sum[WIDTH-1:0];
            nxt_c   = sum[WIDTH];
            nxt_ovf = (s1_q.a[MSB] != s1_q.b[MSB]) && (nxt_r[MSB] != s1_q.a[MSB]);
         end
         OP_NOTB: nxt_r = ~s1_q.b;
         OP_LTU:  nxt_r = {{(WIDTH-1){1'b0}}, (s1_q.a < s1_q.b)};
         OP_LTS:  nxt_r = {{(WIDTH-1){1'b0}}, ($signed(s1_q.a) < $signed(s1_q.b))};
         OP_AND:  nxt_r = s1_q.a & s1_q.b;
         OP_OR:   nxt_r = s1_q.a | s1_q.b;
         OP_XOR:  nxt_r = s1_q.a ^ s1_q.b;
         default: nxt_r = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_q     <= '{op: op_e'(op), a: a, b: b};
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         r        <= '0;
         carry    <= 1'b0;
         ovf      <= 1'b0;
         zero     <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         r        <= nxt_r;
         carry    <= nxt_c;
         ovf      <= nxt_ovf;
         zero     <= (nxt_r == '0);
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   // A new overflow result takes priority over a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf_sticky <= 1'b0;
      end else if (s2_load && nxt_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_add_sub_logic_pipe.sv
// Bench for add_sub_logic_pipe: directed and random ops scored against an arithmetic reference queue.
module tb_add_sub_logic_pipe;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] r;
   logic        carry;
   logic        ovf;
   logic        zero;
   logic        ovf_sticky;
   logic        ovf_clr;

   add_sub_logic_pipe #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .r          (r),
      .carry      (carry),
      .ovf        (ovf),
      .zero       (zero),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] r;
      logic        c;
      logic        v;
      logic        z;
      int          iss;
      bit          pres;
   } ent_t;

   ent_t q[$];
   int   cnt = 0;
   int   ncmp = 0;
   int   nfail = 0;
   bit   sticky_m = 1'b0;
   bit   acc;
   int   n;
   int   n4;
   int   guard;

   function automatic ent_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      ent_t m;
      int ux, uy, sx, sy, t, st;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      m.r = 16'h0;
      m.c = 1'b0;
      m.v = 1'b0;
      m.iss = 0;
      m.pres = 1'b0;
      case (o)
         3'd0: begin
            t = ux + uy;
            st = sx + sy;
            m.r = t[15:0];
            m.c = (t > 65535);
            m.v = (st > 32767) || (st < -32768);
         end
         3'd1: begin
            t = ux - uy;
            st = sx - sy;
            m.r = t[15:0];
            m.c = (ux >= uy);
            m.v = (st > 32767) || (st < -32768);
         end
         3'd2: m.r = ~y;
         3'd3: m.r = (ux < uy) ? 16'd1 : 16'd0;
         3'd4: m.r = (sx < sy) ? 16'd1 : 16'd0;
         3'd5: m.r = x & y;
         3'd6: m.r = x | y;
         default: m.r = x ^ y;
      endcase
      m.z = (m.r == 16'h0);
      return m;
   endfunction

   function automatic logic [15:0] rnd16();
      logic [15:0] edge_vals [4];
      edge_vals[0] = 16'h0000;
      edge_vals[1] = 16'hFFFF;
      edge_vals[2] = 16'h7FFF;
      edge_vals[3] = 16'h8000;
      if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_r", 32'(r), 32'(0));
      chk("rst_carry", 32'(carry), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      chk("rst_zero", 32'(zero), 32'(0));
      chk("rst_sticky", 32'(ovf_sticky), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(1));
   endtask

   // Entered at posedge+1; drives inputs, checks mid-cycle, advances the model across the edge.
   task automatic step(input bit iv, input logic [2:0] o, input logic [15:0] aa, input logic [15:0] bb,
                       input bit ordy, input bit clr, output bit accepted);
      bit   exp_rdy, exp_ov, cons, set;
      ent_t e, h;
      in_valid = iv; op = o; a = aa; b = bb; out_ready = ordy; ovf_clr = clr;
      #3;
      exp_rdy = (q.size() < 2) || ordy;
      exp_ov  = (q.size() > 0) && (cnt - q[0].iss >= 1);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(sticky_m));
      if (exp_ov) begin
         chk("r", 32'(r), 32'(q[0].r));
         chk("carry", 32'(carry), 32'(q[0].c));
         chk("ovf", 32'(ovf), 32'(q[0].v));
         chk("zero", 32'(zero), 32'(q[0].z));
      end
      accepted = iv && exp_rdy;
      cons = exp_ov && ordy;
      @(posedge clk);
      cnt++;
      if (cons) void'(q.pop_front());
      if (accepted) begin
         e = model(o, aa, bb);
         e.iss = cnt;
         q.push_back(e);
      end
      set = 1'b0;
      if (q.size() > 0 && (cnt - q[0].iss >= 1) && !q[0].pres) begin
         h = q[0];
         h.pres = 1'b1;
         q[0] = h;
         set = h.v;
      end
      sticky_m = set ? 1'b1 : (clr ? 1'b0 : sticky_m);
      #1;
   endtask

   task automatic idle(input int k);
      bit dummy;
      for (int i = 0; i < k; i++) step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b0, dummy);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = 16'h0; b = 16'h0;
      out_ready = 1'b1; ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_reset();

      // add with and without carry-out
      step(1'b1, 3'd0, 16'd2, 16'd3, 1'b1, 1'b0, acc);
      step(1'b1, 3'd0, 16'hFFFF, 16'd1, 1'b1, 1'b0, acc);
      idle(3);

      // subtract with borrow, then signed overflow
      step(1'b1, 3'd1, 16'd100, 16'd200, 1'b1, 1'b0, acc);
      step(1'b1, 3'd1, 16'h8000, 16'd1, 1'b1, 1'b0, acc);
      idle(3);
      chk("sticky_after_sub_ovf", 32'(ovf_sticky), 32'(1));
      step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1, acc);

      // NOTB and compares
      step(1'b1, 3'd2, 16'd7, 16'd11, 1'b1, 1'b0, acc);
      step(1'b1, 3'd3, 16'd3, 16'd10, 1'b1, 1'b0, acc);
      step(1'b1, 3'd4, 16'hFFFF, 16'd1, 1'b1, 1'b0, acc);
      step(1'b1, 3'd3, 16'hFFFF, 16'd1, 1'b1, 1'b0, acc);
      idle(3);

      // clear without overflow, then clear colliding with an overflow load
      step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1, acc);
      chk("sticky_clr_no_ovf", 32'(ovf_sticky), 32'(0));
      step(1'b1, 3'd0, 16'h7FFF, 16'd1, 1'b1, 1'b0, acc);
      step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1, acc);
      idle(1);
      chk("sticky_set_wins", 32'(ovf_sticky), 32'(1));
      step(1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 1'b1, acc);
      idle(1);

      // eight back-to-back ops into a stalled consumer
      n = 0; n4 = 0; guard = 0;
      while (n < 8 && guard < 40) begin
         step(1'b1, 3'(n), rnd16(), rnd16(), guard >= 4, 1'b0, acc);
         if (acc) n++;
         guard++;
         if (guard == 4) n4 = n;
      end
      chk("stall_accepts", 32'(n4), 32'(2));
      chk("burst_accepts", 32'(n), 32'(8));
      idle(4);

      // randomized traffic with random stalls and clears
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rnd16(), rnd16(),
              $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0, acc);
      end
      idle(4);

      // reset with two ops in flight
      step(1'b1, 3'd0, 16'h7FFF, 16'd1, 1'b0, 1'b0, acc);
      step(1'b1, 3'd1, 16'd5, 16'd9, 1'b0, 1'b0, acc);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      cnt++;
      q.delete();
      sticky_m = 1'b0;
      #1;
      rst_n = 1'b1;
      chk_reset();
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
